// File: rtl/key_event_arbiter_pkg.sv
// ============================================================================
//  key_pkg
//  Shared types for the key event arbiter: per-key FSM states and the event
//  kind encoding.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } key_fsm_e;

  localparam logic EVT_SHORT = 1'b0;
  localparam logic EVT_LONG  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/key_press_fsm.sv
// ============================================================================
//  key_press_fsm
//  One key: 2-FF synchroniser, debounce/hold FSM, and short/long post pulses.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module key_press_fsm
  import key_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 10,
  parameter int LONG_TICKS     = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  input  logic tick,
  output logic key_state,
  output logic post_short,
  output logic post_long
);

  localparam int DBW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW  = $clog2(LONG_TICKS + 1);
  localparam logic [DBW-1:0] c_db_max   = DBW'(DEBOUNCE_TICKS);
  localparam logic [HW-1:0]  c_hold_max = HW'(LONG_TICKS);

  logic [1:0]     r_sync;
  logic           w_s;
  key_fsm_e       r_state, w_state_nxt;
  logic [DBW-1:0] r_db_cnt, w_db_cnt_nxt;
  logic [HW-1:0]  r_hold_cnt, w_hold_cnt_nxt;
  logic           r_long_done, w_long_done_nxt;
  logic           r_key_state, w_key_state_nxt;

  assign w_s       = r_sync[1];
  assign key_state = r_key_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync      <= 2'b11;
      r_state     <= IDLE;
      r_db_cnt    <= '0;
      r_hold_cnt  <= '0;
      r_long_done <= 1'b0;
      r_key_state <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], key_n};
      r_state     <= w_state_nxt;
      r_db_cnt    <= w_db_cnt_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_long_done <= w_long_done_nxt;
      r_key_state <= w_key_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_db_cnt_nxt    = r_db_cnt;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_long_done_nxt = r_long_done;
    w_key_state_nxt = r_key_state;
    post_short      = 1'b0;
    post_long       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_s) begin
          w_state_nxt  = PRESS_DB;
          w_db_cnt_nxt = '0;
        end
      end
      PRESS_DB: begin
        if (w_s) begin
          w_state_nxt = IDLE;
        end else if (r_db_cnt == c_db_max) begin
          w_state_nxt     = HELD;
          w_hold_cnt_nxt  = '0;
          w_key_state_nxt = 1'b1;
          w_long_done_nxt = 1'b0;
        end else if (tick) begin
          w_db_cnt_nxt = r_db_cnt + DBW'(1);
        end
      end
      HELD: begin
        // The long event fires once, when the saturated count is first seen.
        if (r_hold_cnt == c_hold_max && !r_long_done) begin
          post_long       = 1'b1;
          w_long_done_nxt = 1'b1;
        end
        if (tick && r_hold_cnt != c_hold_max) begin
          w_hold_cnt_nxt = r_hold_cnt + HW'(1);
        end
        if (w_s) begin
          w_state_nxt  = RELEASE_DB;
          w_db_cnt_nxt = '0;
        end
      end
      RELEASE_DB: begin
        if (!w_s) begin
          w_state_nxt = HELD;
        end else if (r_db_cnt == c_db_max) begin
          w_state_nxt     = IDLE;
          w_key_state_nxt = 1'b0;
          post_short      = !r_long_done;
        end else if (tick) begin
          w_db_cnt_nxt = r_db_cnt + DBW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/key_event_arbiter.sv
// ============================================================================
//  key_event_arbiter
//  Debounced short/long key events merged onto one valid/ready port by a
//  round-robin arbiter with one pending slot per key.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module key_event_arbiter
  import key_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int TICK_DIV       = 50_000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int LONG_TICKS     = 1000,
  parameter int KW             = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KW-1:0]       evt_key,
  output logic                evt_long,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                overrun
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] c_presc_max = PW'(TICK_DIV - 1);
  localparam logic [KW-1:0] c_last_key  = KW'(NUM_KEYS - 1);

  logic [PW-1:0]       r_presc;
  logic                w_tick;
  logic [NUM_KEYS-1:0] w_post_short, w_post_long, w_post, w_drop, w_clr;
  logic [NUM_KEYS-1:0] r_pend, r_pend_long;
  logic [KW-1:0]       r_ptr, w_idx, r_evt_key;
  logic                w_any, w_free, w_load;
  logic                r_valid, r_long, r_overrun;

  assign w_tick = (r_presc == c_presc_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_press_fsm #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .LONG_TICKS    (LONG_TICKS)
    ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .key_n     (key_n[k]),
      .tick      (w_tick),
      .key_state (key_state[k]),
      .post_short(w_post_short[k]),
      .post_long (w_post_long[k])
    );
  end

  assign w_post = w_post_short | w_post_long;
  assign w_free = !r_valid || evt_ready;
  assign w_load = w_free && w_any;

  // First pending key after the last granted one, wrapping at NUM_KEYS.
  always_comb begin
    logic [KW-1:0] cand;
    w_any = 1'b0;
    w_idx = '0;
    cand  = r_ptr;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cand = (cand == c_last_key) ? '0 : cand + KW'(1);
      if (!w_any && r_pend[cand]) begin
        w_any = 1'b1;
        w_idx = cand;
      end
    end
  end

  always_comb begin
    w_clr = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      w_clr[k] = w_load && (w_idx == KW'(k));
    end
  end

  // A key whose slot is being emptied this cycle can take a new event.
  assign w_drop = w_post & r_pend & ~w_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend      <= '0;
      r_pend_long <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= |w_drop;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (w_post[k] && !w_drop[k]) begin
          r_pend[k]      <= 1'b1;
          r_pend_long[k] <= w_post_long[k] ? EVT_LONG : EVT_SHORT;
        end else if (w_clr[k]) begin
          r_pend[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_evt_key <= '0;
      r_long    <= 1'b0;
      r_ptr     <= c_last_key;
    end else if (w_free) begin
      if (w_any) begin
        r_valid   <= 1'b1;
        r_evt_key <= w_idx;
        r_long    <= r_pend_long[w_idx];
        r_ptr     <= w_idx;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign evt_valid = r_valid;
  assign evt_key   = r_evt_key;
  assign evt_long  = r_long;
  assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_key_event_arbiter.sv
// ============================================================================
//  tb_key_event_arbiter
//  Directed scenarios plus random key activity against a behavioural model.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_event_arbiter;

  localparam int NK = 4;
  localparam int TD = 10;
  localparam int DB = 3;
  localparam int LT = 20;
  localparam int KW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_n = '1;
  logic          evt_ready = 1'b1;
  logic          evt_valid, evt_long, overrun;
  logic [KW-1:0] evt_key;
  logic [NK-1:0] key_state;

  key_event_arbiter #(
    .NUM_KEYS      (NK),
    .TICK_DIV      (TD),
    .DEBOUNCE_TICKS(DB),
    .LONG_TICKS    (LT),
    .KW            (KW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_n    (key_n),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_key  (evt_key),
    .evt_long (evt_long),
    .key_state(key_state),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int ovr_cnt = 0;
  int dq_key[$];
  int dq_long[$];
  int dq_cyc[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each key is a debounced level plus a flag saying a level change is being
  // qualified; events go into a one-deep slot per key, then a rotating search.
  logic [NK-1:0] m_s0, m_s1;
  bit            m_deb[NK], m_indb[NK], m_sent[NK], m_pend[NK], m_plong[NK];
  int            m_cnt[NK], m_hold[NK];
  int            m_ptr, m_cyc;
  bit            exp_valid, exp_long, exp_ovr;
  int            exp_key;
  logic [NK-1:0] exp_ks;

  task automatic model_reset();
    m_s0 = '1; m_s1 = '1;
    for (int k = 0; k < NK; k++) begin
      m_deb[k] = 0; m_indb[k] = 0; m_sent[k] = 0; m_pend[k] = 0; m_plong[k] = 0;
      m_cnt[k] = 0; m_hold[k] = 0;
    end
    m_ptr = NK - 1; m_cyc = 0;
    exp_valid = 0; exp_long = 0; exp_ovr = 0; exp_key = 0; exp_ks = '0;
  endtask

  task automatic model_step();
    bit tick, pressed, free, ovr;
    bit ps[NK], pl[NK], pre[NK];
    int g;
    tick = ((m_cyc % TD) == TD - 1);
    m_cyc++;
    for (int k = 0; k < NK; k++) begin
      pressed = !m_s1[k];
      ps[k] = 0; pl[k] = 0;
      if (!m_indb[k]) begin
        if (m_deb[k]) begin
          if (m_hold[k] == LT && !m_sent[k]) begin pl[k] = 1; m_sent[k] = 1; end
          if (tick && m_hold[k] < LT) m_hold[k]++;
        end
        if (pressed != m_deb[k]) begin m_indb[k] = 1; m_cnt[k] = 0; end
      end else begin
        if (pressed == m_deb[k]) m_indb[k] = 0;
        else if (m_cnt[k] == DB) begin
          m_indb[k] = 0;
          m_deb[k]  = !m_deb[k];
          if (m_deb[k]) begin m_hold[k] = 0; m_sent[k] = 0; end
          else if (!m_sent[k]) ps[k] = 1;
        end else if (tick) m_cnt[k]++;
      end
    end
    m_s1 = m_s0;
    m_s0 = key_n;
    for (int k = 0; k < NK; k++) pre[k] = m_pend[k];
    free = !exp_valid || evt_ready;
    g = -1;
    if (free) begin
      for (int i = 1; i <= NK; i++)
        if (g < 0 && m_pend[(m_ptr + i) % NK]) g = (m_ptr + i) % NK;
      if (g >= 0) begin
        exp_valid = 1; exp_key = g; exp_long = m_plong[g]; m_ptr = g; m_pend[g] = 0;
      end else exp_valid = 0;
    end
    ovr = 0;
    for (int k = 0; k < NK; k++) begin
      if (ps[k] || pl[k]) begin
        if (pre[k] && g != k) ovr = 1;
        else begin m_pend[k] = 1; m_plong[k] = pl[k]; end
      end
      exp_ks[k] = m_deb[k];
    end
    exp_ovr = ovr;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Delivery log from the DUT port, taken at the accepting edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst && evt_valid && evt_ready) begin
      dq_key.push_back(int'(evt_key));
      dq_long.push_back(int'(evt_long));
      dq_cyc.push_back(cyc);
    end
  end

  // Cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("evt_valid", int'(evt_valid), int'(exp_valid));
      if (exp_valid) begin
        chk("evt_key", int'(evt_key), exp_key);
        chk("evt_long", int'(evt_long), int'(exp_long));
      end
      chk("key_state", int'(key_state), int'(exp_ks));
      chk("overrun", int'(overrun), int'(exp_ovr));
      if (overrun) ovr_cnt++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    key_n = '1;
    evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    dq_key.delete(); dq_long.delete(); dq_cyc.delete();
    ovr_cnt = 0;
  endtask

  int t0, rise, waited, stable_bad, ks_seen;
  int rem[NK];

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_key_state", int'(key_state), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_key_long", int'({evt_key, evt_long}), 0);
    rst = 1'b0;

    // 1: short press on key 1
    do_reset();
    t0 = cyc; rise = -1;
    key_n[1] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rise < 0 && key_state[1]) rise = cyc - t0;
    end
    chk_range("short_ks_rise", rise, 20, 45);
    t0 = cyc;
    key_n[1] = 1'b1;
    waited = 0;
    while (dq_key.size() == 0 && waited < 80) begin @(negedge clk); waited++; end
    chk("short_evt_timeout", int'(dq_key.size() > 0), 1);
    if (dq_key.size() > 0) begin
      chk_range("short_latency", dq_cyc[0] - t0, 20, 50);
      chk("short_key", dq_key[0], 1);
      chk("short_long", dq_long[0], 0);
    end
    repeat (50) @(negedge clk);
    chk("short_count", dq_key.size(), 1);

    // 2: bounce rejection on key 2
    do_reset();
    ks_seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (i % 15 == 0) key_n[2] = ((i / 15) % 2 == 1);
      @(negedge clk);
      if (key_state[2]) ks_seen = 1;
    end
    key_n[2] = 1'b1;
    repeat (60) begin @(negedge clk); if (key_state[2]) ks_seen = 1; end
    chk("bounce_key_state", ks_seen, 0);
    chk("bounce_events", dq_key.size(), 0);

    // 3: long press on key 0
    do_reset();
    t0 = cyc;
    key_n[0] = 1'b0;
    repeat (400) @(negedge clk);
    key_n[0] = 1'b1;
    repeat (80) @(negedge clk);
    chk("long_count", dq_key.size(), 1);
    if (dq_key.size() > 0) begin
      chk_range("long_latency", dq_cyc[0] - t0, 210, 255);
      chk("long_key", dq_key[0], 0);
      chk("long_long", dq_long[0], 1);
    end

    // 4: simultaneous posts on 0, 2, 3 with a stalled consumer
    do_reset();
    evt_ready = 1'b0;
    key_n = 4'b0010;
    repeat (60) @(negedge clk);
    key_n = '1;
    waited = 0;
    while (!evt_valid && waited < 80) begin @(negedge clk); waited++; end
    chk("rr_valid_timeout", int'(evt_valid), 1);
    stable_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!evt_valid || evt_key != 2'd0 || evt_long) stable_bad++;
    end
    chk("rr_stall_stable", stable_bad, 0);
    evt_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("rr_count", dq_key.size(), 3);
    if (dq_key.size() == 3) begin
      chk("rr_key0", dq_key[0], 0);
      chk("rr_key1", dq_key[1], 2);
      chk("rr_key2", dq_key[2], 3);
      chk("rr_back_to_back", dq_cyc[2] - dq_cyc[0], 2);
    end

    // 5: overrun on key 3 while the output holds a key 0 event
    do_reset();
    evt_ready = 1'b0;
    key_n[0] = 1'b0; repeat (60) @(negedge clk); key_n[0] = 1'b1; repeat (60) @(negedge clk);
    key_n[3] = 1'b0; repeat (60) @(negedge clk); key_n[3] = 1'b1; repeat (60) @(negedge clk);
    key_n[3] = 1'b0; repeat (60) @(negedge clk); key_n[3] = 1'b1; repeat (60) @(negedge clk);
    evt_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("ovr_pulses", ovr_cnt, 1);
    chk("ovr_delivered", dq_key.size(), 2);
    if (dq_key.size() == 2) begin
      chk("ovr_first", dq_key[0], 0);
      chk("ovr_second", dq_key[1], 3);
    end

    // 6: async reset while an event is presented and another pending
    do_reset();
    evt_ready = 1'b0;
    key_n = 4'b0101;
    repeat (60) @(negedge clk);
    key_n = '1;
    waited = 0;
    while (!evt_valid && waited < 80) begin @(negedge clk); waited++; end
    chk("arst_valid_before", int'(evt_valid), 1);
    key_n[2] = 1'b0;
    waited = 0;
    while (!key_state[2] && waited < 80) begin @(negedge clk); waited++; end
    chk("arst_ks_before", int'(key_state[2]), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", int'(evt_valid), 0);
    chk("arst_key_state", int'(key_state), 0);
    key_n = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    dq_key.delete(); dq_long.delete(); dq_cyc.delete();
    evt_ready = 1'b1;
    repeat (300) @(negedge clk);
    chk("arst_no_events", dq_key.size(), 0);

    // random key activity and consumer back-pressure
    do_reset();
    for (int k = 0; k < NK; k++) rem[k] = $urandom_range(5, 60);
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      evt_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NK; k++) begin
        if (rem[k] == 0) begin
          key_n[k] = ~key_n[k];
          case ($urandom_range(0, 5))
            0:       rem[k] = $urandom_range(1, 12);
            1:       rem[k] = $urandom_range(220, 320);
            default: rem[k] = $urandom_range(40, 140);
          endcase
        end else rem[k]--;
      end
    end
    key_n = '1;
    evt_ready = 1'b1;
    repeat (100) @(negedge clk);
    chk("random_some_events", int'(dq_key.size() > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_event_arbiter.md
Name: key_event_arbiter

Overview:
Debounces and classifies presses on NUM_KEYS active-low push-buttons. Each debounced press becomes a short-press or long-press event. Events from all keys are shared onto one valid/ready event port by a round-robin arbiter. Sits between the board key pins and the UI/control logic.

Parameters:
NUM_KEYS, 4, number of key inputs (2..16)
TICK_DIV, 50_000, clk cycles per timebase tick (1 ms at 50 MHz)
DEBOUNCE_TICKS, 10, ticks a level must be stable to be accepted
LONG_TICKS, 1000, ticks of debounced hold that make a long press
KW, $clog2(NUM_KEYS), width of the key index

Ports:
clk, in, 1, system clock
rst, in, 1, reset; asynchronous, active-high
key_n, in, NUM_KEYS, raw key pins; 0 = pressed; asynchronous to clk
evt_valid, out, 1, event available on evt_key/evt_long
evt_ready, in, 1, consumer accepts the event when valid && ready
evt_key, out, KW, index of the key that produced the event
evt_long, out, 1, 1 = long press, 0 = short press
key_state, out, NUM_KEYS, debounced level per key; 1 = held
overrun, out, 1, one-cycle pulse when an event is dropped

Behaviour:
- Reset (async, rst=1): all of the following are forced.
  - Synchronisers = 1 (released). Prescaler = 0. All FSMs go to IDLE. Counters = 0.
  - pending = 0. evt_valid = 0, evt_key = 0, evt_long = 0, key_state = 0, overrun = 0.
  - Round-robin pointer = NUM_KEYS-1, so key 0 wins first.
  - Reset mid-operation discards all pending and presented events.
- Synchroniser: a 2-FF chain per key. The FSM sees only the synchronised level s.
- Timebase: a shared prescaler counts 0..TICK_DIV-1. tick = 1 for one cycle when the count equals TICK_DIV-1, then the count wraps to 0.
- Per-key FSM states and transitions:
  - IDLE:
    - s=0 -> PRESS_DB, db_cnt=0.
  - PRESS_DB:
    - s=1 -> IDLE (bounce rejected).
    - On tick, db_cnt++.
    - When db_cnt reaches DEBOUNCE_TICKS: -> HELD, hold_cnt=0, key_state=1, long_done=0.
  - HELD:
    - On tick, hold_cnt++, saturating at LONG_TICKS.
    - When hold_cnt reaches LONG_TICKS and long_done=0: post a long event, set long_done=1.
    - s=1 -> RELEASE_DB, db_cnt=0. hold_cnt is frozen while in RELEASE_DB.
  - RELEASE_DB:
    - s=0 -> HELD (release bounce). hold_cnt and long_done are retained.
    - On tick, db_cnt++.
    - When db_cnt reaches DEBOUNCE_TICKS: -> IDLE, key_state=0. If long_done=0, post a short event.
  - Consequences: a long press posts exactly one event, at the long threshold (not at release). A short press posts one event, at debounced release.
- Pending store:
  - One pending bit plus one long bit per key.
  - A post sets them at the clock edge following the post condition.
  - Post while the key's pending bit is already set: the new event is dropped, the old event is kept, and overrun pulses for 1 cycle.
  - Post in the same cycle that the arbiter loads that key's pending event: the old event is loaded, the new event becomes pending, no overrun.
- Arbiter and output:
  - The output register is free when evt_valid=0, or when evt_valid && evt_ready.
  - When free and any pending bit is set, the grant goes to the first pending key searching from pointer+1 modulo NUM_KEYS.
  - On grant: load evt_key/evt_long, set evt_valid=1, clear that pending bit, set pointer = granted index. All of this happens in the same edge.
  - Back-to-back: acceptance and the next load happen in the same cycle, giving one event per cycle max.
  - evt_key/evt_long are held stable while evt_valid && !evt_ready.
  - When free and nothing is pending, evt_valid drops to 0.
- Latency: post condition at cycle N -> pending set at edge N+1 -> evt_valid=1 after edge N+2 (output free case).
- Widths:
  - db_cnt is $clog2(DEBOUNCE_TICKS+1) bits.
  - hold_cnt is $clog2(LONG_TICKS+1) bits.
  - The prescaler is $clog2(TICK_DIV) bits.
  - No wrap of db_cnt or hold_cnt is allowed.

Decomposition:
- Package key_pkg holds:
  - The FSM state enum: IDLE, PRESS_DB, HELD, RELEASE_DB.
  - Event encoding constants: EVT_SHORT=0, EVT_LONG=1.
- Sub-module key_press_fsm (one per key, generate loop) holds the synchroniser, FSM, counters and key_state. Its outputs are post_short and post_long pulses.
- The prescaler, pending store and round-robin arbiter live in the top level.

Test Plan:
All scenarios run with TICK_DIV=10, DEBOUNCE_TICKS=3, LONG_TICKS=20, NUM_KEYS=4, evt_ready=1 unless stated.
1. Short press: key_n[1]=0 for 100 cycles, then 1. Required: key_state[1] rises ~30-40 cycles after the press; exactly one event, evt_key=1, evt_long=0, ~30-40 cycles after release.
2. Bounce reject: key_n[2] toggles every 15 cycles for 200 cycles, then stays 1. Required: no event, key_state[2] stays 0.
3. Long press: key_n[0]=0 for 400 cycles. Required: one event, evt_key=0, evt_long=1, ~230-250 cycles after the press; no event at release.
4. Round-robin: posts on keys 0, 2 and 3 land in the same cycle, with evt_ready=0 for 20 cycles, then 1. Required: evt_key sequence 0, 2, 3 on consecutive cycles; payload stable while stalled.
5. Overrun: evt_ready=0, then two short presses on key 3. Required: overrun pulses once; after evt_ready=1, only the first event is delivered.
6. Async reset mid-press with evt_valid=1: assert rst. Required: evt_valid, key_state and pending all clear immediately; no event after release.
